// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
// Purpose: FSM state encoding and default operand width used by serial_adder.
// Ports: none (package).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int W_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - single-bit combinational full adder
// Purpose: one-bit sum/carry cell shared by every bit position of the serial adder.
// Ports:
//   a, b  - operand bits
//   c     - carry in
//   s     - sum bit
//   cout  - carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit with valid/ready handshakes
// Purpose: accepts two W-bit operands, adds (a+b+cin) or subtracts (a-b) them
//          one bit per cycle LSB first, and presents the result until consumed.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (in_ready only in IDLE)
//   a, b, cin, sub       - operands, carry-in (add only), 1 = subtract
//   out_valid / out_ready- result handshake (out_valid only in DONE)
//   sum, cout, ovf       - result, carry out of MSB, signed overflow
//   busy                 - operation in progress or result pending
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_sh_q;
  logic [W-1:0]  sum_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic          sub_q;
  logic          cout_q;
  logic          ovf_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;

  logic          fa_s;
  logic          fa_co;
  logic [W-1:0]  sum_d;
  logic          accept;

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0] ^ sub_q),
    .c    (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // New bit enters at the MSB so that after W shifts bit 0 holds the LSB.
  always_comb begin
    sum_d        = sum_sh_q >> 1;
    sum_d[W-1]   = fa_s;
  end

  assign accept = in_valid & in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_RUN;
            a_q        <= a;
            b_q        <= b;
            sub_q      <= sub;
            // Subtraction is a + ~b + 1, so the carry chain starts at 1.
            carry_q    <= sub ? 1'b1 : cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          sum_sh_q <= sum_d;
          carry_q  <= fa_co;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q     <= ST_DONE;
            sum_q       <= sum_d;
            cout_q      <= fa_co;
            // carry_q is the carry into the MSB while the MSB is processed.
            ovf_q       <= carry_q ^ fa_co;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (W=8 and W=1)
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       cin;
  logic       sub;
  logic       out_ready;
  logic       sel;
  logic [7:0] a;
  logic [7:0] b;

  logic       rdy8, ov8, co8, of8, bz8;
  logic [7:0] s8;
  logic       rdy1, ov1, co1, of1, bz1;
  logic [0:0] s1;

  logic       obs_rdy, obs_valid, obs_cout, obs_ovf, obs_busy;
  logic [7:0] obs_sum;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_adder #(.W(8)) u_d8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & ~sel),
    .in_ready  (rdy8),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (ov8),
    .out_ready (out_ready & ~sel),
    .sum       (s8),
    .cout      (co8),
    .ovf       (of8),
    .busy      (bz8)
  );

  serial_adder #(.W(1)) u_d1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & sel),
    .in_ready  (rdy1),
    .a         (a[0:0]),
    .b         (b[0:0]),
    .cin       (cin),
    .sub       (sub),
    .out_valid (ov1),
    .out_ready (out_ready & sel),
    .sum       (s1),
    .cout      (co1),
    .ovf       (of1),
    .busy      (bz1)
  );

  assign obs_rdy   = sel ? rdy1 : rdy8;
  assign obs_valid = sel ? ov1  : ov8;
  assign obs_cout  = sel ? co1  : co8;
  assign obs_ovf   = sel ? of1  : of8;
  assign obs_busy  = sel ? bz1  : bz8;
  assign obs_sum   = sel ? {7'd0, s1} : s8;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the w-bit operands.
  // Returns {ovf, cout, sum[7:0]}.
  function automatic logic [9:0] model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                        input logic ci, input logic is_sub);
    longint mask, ua, ub, full, sa, sb2, res, half;
    logic [9:0] r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(av) & mask;
    ub   = longint'(bv) & mask;
    full = is_sub ? ua + ((~ub) & mask) + 1 : ua + ub + longint'(ci);
    sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
    sb2  = (ub >= half) ? ub - (longint'(1) << w) : ub;
    res  = is_sub ? sa - sb2 : sa + sb2 + longint'(ci);
    r[7:0] = 8'(full & mask);
    r[8]   = 1'((full >> w) & 1);
    r[9]   = (res > half - 1) || (res < -half);
    return r;
  endfunction

  task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic is_sub,
                    input int hold, input logic [7:0] es, input logic ec, input logic eo);
    int w;
    int n;
    w = sel ? 1 : 8;
    n = 0;
    while (!obs_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_pre", obs_rdy, 1);
    a = av; b = bv; cin = ci; sub = is_sub; in_valid = 1'b1;
    @(posedge clk); #1;
    // Operands scrambled and stray handshakes asserted while the operation runs.
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    out_ready = 1'($urandom);
    chk("in_ready_run", obs_rdy, 0);
    chk("busy_run", obs_busy, 1);
    n = 0;
    while (!obs_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("latency", n, w);
    chk("sum", obs_sum, es);
    chk("cout", obs_cout, ec);
    chk("ovf", obs_ovf, eo);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", obs_valid, 1);
      chk("hold_in_ready", obs_rdy, 0);
      chk("hold_sum", obs_sum, es);
      chk("hold_cout", obs_cout, ec);
      chk("hold_ovf", obs_ovf, eo);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", obs_valid, 0);
    chk("post_in_ready", obs_rdy, 1);
    chk("post_busy", obs_busy, 0);
    chk("post_sum_kept", obs_sum, es);
  endtask

  task automatic rand_op(input int w);
    logic [7:0]  av, bv;
    logic        ci, sb;
    logic [9:0]  e;
    av = 8'($urandom); bv = 8'($urandom);
    ci = 1'($urandom); sb = 1'($urandom);
    e  = model(w, av, bv, ci, sb);
    op(av, bv, ci, sb, int'($urandom_range(0, 3)), e[7:0], e[8], e[9]);
  endtask

  initial begin
    logic [9:0] e;
    rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0; sel = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum8", s8, 0);
    chk("rst_flags8", {co8, of8, ov8, bz8, rdy8}, 0);
    chk("rst_flags1", {s1, co1, of1, ov1, bz1, rdy1}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready8", rdy8, 1);
    chk("rel_in_ready1", rdy1, 1);

    // Directed W=8 cases.
    op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 8'h10, 1'b0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1, 8'h00, 1'b1, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1);
    op(8'h05, 8'h07, 1'b1, 1'b1, 5, 8'hFE, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) rand_op(8);

    // W=1 exhaustive add truth table, then random add/sub.
    sel = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      int         tot;
      v   = 3'(i);
      tot = int'(v[2]) + int'(v[1]) + int'(v[0]);
      op({7'd0, v[2]}, {7'd0, v[1]}, v[0], 1'b0, 0,
         8'(tot % 2), 1'(tot / 2), 1'(v[2] == v[1] && v[2] != 1'(tot % 2)));
    end
    for (int i = 0; i < 10; i++) rand_op(1);
    sel = 1'b0;
    @(posedge clk); #1;

    // Reset mid-operation, after a result with non-zero flags is held.
    op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1);
    a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_sum", s8, 0);
    chk("abort_flags", {co8, of8, ov8, bz8, rdy8}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", rdy8, 1);
    e = model(8, 8'h12, 8'h34, 1'b0, 1'b0);
    chk("model_12_34", e, 10'h046);
    op(8'h12, 8'h34, 1'b0, 1'b0, 1, 8'h46, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter W, default 8, operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand request present.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  W  first operand.
REQ-007 b  input  W  second operand.
REQ-008 cin  input  1  carry-in; used only in add mode.
REQ-009 sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  W  result bits.
REQ-013 cout  output  1  carry out of the MSB.
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 busy  output  1  high while in RUN or DONE.

Function
REQ-016 FSM states are IDLE, RUN and DONE; reset state is IDLE.
REQ-017 in_ready is 1 in IDLE only; out_valid is 1 in DONE only.
REQ-018 IDLE->RUN occurs on a clock edge with in_valid=1 and in_ready=1. On that edge the block captures a, b, cin and sub, and clears the bit counter to 0.
REQ-019 In RUN, one result bit is computed per cycle, LSB first, by the full-adder cell from the captured a bit, the captured b bit (inverted when sub=1) and the carry flip-flop.
REQ-020 The carry flip-flop initialises at capture: to cin when sub=0, and to 1 when sub=1 (cin ignored).
REQ-021 The bit counter counts 0..W-1 with width max(1,clog2(W)). RUN->DONE occurs on the edge that processes bit W-1. W=1 therefore gives exactly one RUN cycle.
REQ-022 Latency: out_valid rises exactly W cycles after the accept edge.
REQ-023 On RUN->DONE: cout is the final carry, and ovf is the carry into the MSB XOR the carry out of the MSB.
REQ-024 In DONE, sum, cout and ovf are held stable until out_ready=1. DONE->IDLE occurs on the edge where out_valid and out_ready are both 1.
REQ-025 Result registers retain their last values after DONE->IDLE; they change only on the next RUN->DONE.
REQ-026 in_valid asserted outside IDLE is ignored. Changes to a, b, cin or sub after the accept edge have no effect on the operation in flight.
REQ-027 out_ready asserted outside DONE is ignored.
REQ-028 No back-to-back overlap: a new operand set is accepted no earlier than the cycle after DONE->IDLE.

Reset
REQ-029 When rst_n=0, the FSM goes immediately to IDLE and all outputs are 0: sum, cout, ovf, out_valid, busy, plus in_ready after release.
REQ-030 Reset during RUN or DONE aborts the operation without producing a result.
REQ-031 After rst_n rises, in_ready=1 on the first clock.

Structure
REQ-032 Package serial_adder_pkg holds the FSM state enum and the default W constant.
REQ-033 The combinational full-adder cell is a separate sub-module, fa_cell, with ports a, b, c, s, cout, instantiated once.
REQ-034 Shift registers for a, b and sum plus the counter; no W-wide adder is inferred.

Verification
REQ-035 W=8, add: a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, ovf=0, out_valid exactly 8 cycles after accept.
REQ-036 W=8, add: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Also a=0x7F, b=0x01 -> sum=0x80, ovf=1.
REQ-037 W=8, sub: a=0x05, b=0x07, cin=1 -> sum=0xFE, cout=0, ovf=0 (cin ignored).
REQ-038 W=1, all 8 combinations of a, b, cin with sub=0 -> sum and cout match the full-adder truth table, each with 1-cycle latency.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout and ovf unchanged and in_ready=0 throughout; in_ready=1 the cycle after the handshake.
REQ-040 Assert rst_n=0 at bit 3 of a W=8 RUN -> all outputs 0 immediately; the next operation, 0x12+0x34, yields 0x46.
